instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

- Instruction fetch stage of the RISC-V pipeline. It produces the instruction stream that the decode stage's control unit consumes.
- It owns the program counter and issues word fetches to instruction memory over a valid/ready request channel plus an in-order response channel.
- It buffers returned instructions with their PCs and presents them to decode with a valid/ready handshake.
- It discards stale fetches when execute redirects the PC on a taken branch or jump.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `DEPTH`, default 4: instruction buffer entries; power of two, ≥2.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_addr` out 32: fetch address, word aligned.
- `imem_req_ready` in 1: memory accepts request.
- `imem_rsp_valid` in 1: response valid; one per accepted request, in order, ≥1 cycle after acceptance.
- `imem_rsp_data` in 32: fetched instruction word.
- `redirect` in 1: taken branch/jump from execute.
- `redirect_pc` in 32: new fetch PC; bits [1:0] ignored.
- `instr_valid` out 1: buffered instruction available to decode.
- `instr_ready` in 1: decode accepts (low = stall).
- `instr` out 32: instruction at buffer head.
- `instr_pc` out 32: PC of `instr`.
- `op` out 7, `func3` out 3, `func7` out 7: `instr[6:0]`, `instr[14:12]`, `instr[31:25]`, driven to the control unit.

## Operation
- Registers:
  - `fetch_pc`: next address to request.
  - `rsp_pc`: PC of the next non-stale response.
  - `outstanding`: accepted requests with no response yet, stale included.
  - `drop_cnt`: stale responses still to discard.
  - buffer `count`.
- Credit: `imem_req_valid = (state != IDLE) && (outstanding + count < DEPTH) && !redirect`. Only registered values are used; same-cycle push/pop/response are not counted.
- Request handshake (`valid && ready`): `fetch_pc += 4`, `outstanding += 1`.
- Response: `outstanding -= 1`.
  - If `drop_cnt > 0`: discard the response and decrement `drop_cnt`.
  - Otherwise: push `{rsp_pc, data}` and set `rsp_pc += 4`.
- Simultaneous request accept and response in one cycle: `outstanding` is unchanged.
- A response arriving while `outstanding == 0` is a protocol violation; ignore it.
- Redirect, which has priority over all other updates that cycle:
  - Set `fetch_pc` and `rsp_pc` to `{redirect_pc[31:2],2'b00}`.
  - Clear the buffer; a pop completing in the same cycle is still considered consumed.
  - Set `drop_cnt = outstanding - imem_rsp_valid`; any response arriving that cycle is discarded.
  - No request is issued that cycle.
- FSM:
  - IDLE: the reset state. Moves to RUN on the first clock edge after `rst` deasserts. No requests are issued in IDLE.
  - RUN: on `redirect`, go to FLUSH if the new `drop_cnt` is nonzero, else stay in RUN.
  - FLUSH: requests continue to issue at the new PC. Return to RUN when the last stale response is dropped. A `redirect` while in FLUSH recomputes `drop_cnt` with the same formula and stays in FLUSH if the result is nonzero.
- Buffer push to a full buffer cannot occur, because credit prevents it. Treat it as an assertion failure.
- Address arithmetic: `fetch_pc` and `rsp_pc` wrap modulo 2^32.

## Timing
- Reset values:
  - `imem_req_valid` = 0
  - `imem_req_addr` = `fetch_pc` = `rsp_pc` = `RESET_PC`
  - `instr_valid` = 0
  - `instr`, `instr_pc`, `op`, `func3`, `func7` = 0
  - `outstanding` = `drop_cnt` = `count` = 0
  - state = IDLE
- Reset asserted mid-operation: everything returns to the reset values immediately. Responses to requests issued before reset are not dropped; the memory must be reset alongside.
- First request: `imem_req_valid` goes high in the second cycle after `rst` falls (one cycle in IDLE).
- Latency: response in cycle M → `instr_valid` in cycle M+1, no bypass.
- Sustained throughput of 1 instruction/cycle requires `DEPTH ≥ memory latency + 2`.
- After `redirect` in cycle R:
  - `instr_valid` = 0 in cycle R+1.
  - The request for `redirect_pc` is presented in cycle R+1.
- `instr`, `instr_pc` and the field outputs hold stable while `instr_valid && !instr_ready`.

## Structure
- Shared package `riscv_pkg`:
  - `XLEN` = 32
  - instruction field bit positions used for `op`/`func3`/`func7`
  - `fetch_state_t` enum {IDLE, RUN, FLUSH}
  - default reset PC constant
- Sub-module `instr_fifo`:
  - `DEPTH` × 64-bit entries of `{pc, instr}`
  - ports: push, pop, flush, count, full, empty
  - pointers wrap at `DEPTH`; flush takes priority over push and pop.

## Test plan
- Reset: release `rst`; memory 1-cycle latency, always ready → requests to 0x0, 0x4, 0x8 in consecutive cycles; `instr_pc` sequence 0x0, 0x4, 0x8 with 1/cycle throughput.
- Backpressure: hold `instr_ready` = 0 → at most `DEPTH` (4) requests in flight plus buffered; `instr` stable. Release → no loss or duplication, PCs contiguous.
- Redirect with 2 in flight: redirect to 0x100 → both stale responses dropped; next `instr_pc` = 0x100, then 0x104.
- Redirect during FLUSH: redirect to 0x200 while `drop_cnt` = 1 → all older responses dropped; first delivered `instr_pc` = 0x200.
- Redirect on a response cycle: redirect together with `imem_rsp_valid` → that response is dropped; misaligned `redirect_pc` = 0x303 → fetch address 0x300.
- Mid-stream reset: assert `rst` with 3 buffered → `instr_valid` = 0 and `imem_req_valid` = 0 immediately; after release, first request to `RESET_PC`.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: data width, instruction field
// positions, fetch FSM states, buffer entry layout and default reset PC.
// No ports; imported by the fetch unit and its instruction buffer.
package riscv_pkg;

  localparam int XLEN = 32;

  // Instruction field bit positions
  localparam int OP_LSB = 0;
  localparam int OP_MSB = 6;
  localparam int F3_LSB = 12;
  localparam int F3_MSB = 14;
  localparam int F7_LSB = 25;
  localparam int F7_MSB = 31;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  // One buffered fetch: 64 bits of {pc, instr}
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fifo.sv
// Instruction buffer: DEPTH entries of {pc, instr}, head readable combinationally.
// Ports: push/push_data write, pop advances head, flush empties (wins over push/pop),
// count/full/empty status. Latency: a push is visible at the head the next cycle.
module instr_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers are AW bits wide, so they wrap at DEPTH (a power of two).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// RISC-V fetch stage: owns the PC, issues credit-limited word fetches, buffers
// {pc, instr} for decode, drops stale responses after a redirect.
// Ports: imem_req_* (valid/ready request), imem_rsp_* (in-order response),
// redirect/redirect_pc from execute, instr_* plus op/func3/func7 toward decode.
// Latency: response in cycle M -> instr_valid in M+1. Backpressure: instr_ready low
// stalls the head; requests stop once outstanding + buffered reaches DEPTH.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  op,
  output logic [2:0]  func3,
  output logic [6:0]  func7
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

  fetch_state_t  state, state_nxt;
  logic [31:0]   fetch_pc, rsp_pc, redirect_tgt;
  logic [CW-1:0] outstanding, out_nxt, drop_cnt, count;
  logic          credit, req_fire, rsp_ok, push, pop, full, empty;
  fetch_entry_t  head;

  assign redirect_tgt = redirect_pc & ~32'h3;

  // Credit uses registered occupancy only, so one slot is reserved per request.
  assign credit         = ({1'b0, outstanding} + {1'b0, count}) < (CW + 1)'(DEPTH);
  assign imem_req_valid = (state != IDLE) && credit && !redirect;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_ok  = imem_rsp_valid && (outstanding != '0);
  // No request fires during a redirect, so out_nxt is also the new drop count.
  assign out_nxt = outstanding + CW'(req_fire) - CW'(rsp_ok);

  assign push = rsp_ok && (drop_cnt == '0) && !redirect;
  assign pop  = instr_valid && instr_ready;

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ('{pc: rsp_pc, instr: imem_rsp_data}),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign instr_valid = !empty;
  assign instr       = empty ? '0 : head.instr;
  assign instr_pc    = empty ? '0 : head.pc;
  assign op          = instr[OP_MSB:OP_LSB];
  assign func3       = instr[F3_MSB:F3_LSB];
  assign func7       = instr[F7_MSB:F7_LSB];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = RUN;
      RUN:     if (redirect && (out_nxt != '0)) state_nxt = FLUSH;
      FLUSH: begin
        if (redirect)
          state_nxt = (out_nxt != '0) ? FLUSH : RUN;
        else if ((drop_cnt == '0) || (rsp_ok && (drop_cnt == CW'(1))))
          state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC_ALIGNED;
      rsp_pc      <= RESET_PC_ALIGNED;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= out_nxt;
      if (redirect) begin
        fetch_pc <= redirect_tgt;
        rsp_pc   <= redirect_tgt;
        drop_cnt <= out_nxt;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_ok) begin
          if (drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
          else                rsp_pc   <= rsp_pc + 32'd4;
        end
      end
    end
  end

  push_into_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        redirect       = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;
  logic        instr_valid;
  logic        instr_ready    = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  op;
  logic [2:0]  func3;
  logic [6:0]  func7;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0), .DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .op             (op),
    .func3          (func3),
    .func7          (func7)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Memory model: accepted addresses in order; head answered when rsp_en is set.
  logic [31:0] q[$];
  logic        rsp_en, ready_en, dec_ready, redir;
  logic [31:0] redir_pc;
  logic [31:0] exp_pc;
  logic        s_rv, s_iv;
  logic [31:0] s_ra, s_ipc;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hFEDC_B9A7;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at posedge+1, sample at negedge, update memory after posedge.
  task automatic tick();
    logic        fire, rfire;
    logic [31:0] w;
    imem_rsp_valid = rsp_en && (q.size() > 0);
    imem_rsp_data  = (q.size() > 0) ? word(q[0]) : 32'h0;
    imem_req_ready = ready_en;
    instr_ready    = dec_ready;
    redirect       = redir;
    redirect_pc    = redir_pc;
    #4;
    s_rv  = imem_req_valid;
    s_ra  = imem_req_addr;
    s_iv  = instr_valid;
    s_ipc = instr_pc;
    if (s_iv) begin
      w = word(s_ipc);
      chk("instr_word", instr, w);
      chk("op", {25'b0, op}, {25'b0, w[6:0]});
      chk("func3", {29'b0, func3}, {29'b0, w[14:12]});
      chk("func7", {25'b0, func7}, {25'b0, w[31:25]});
      if (dec_ready) begin
        chk("deliver_pc", s_ipc, exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
    end
    if (redir) exp_pc = redir_pc & ~32'h3;
    fire  = s_rv && ready_en;
    rfire = imem_rsp_valid;
    @(posedge clk);
    #1;
    if (rfire) void'(q.pop_front());
    if (fire) q.push_back(s_ra);
  endtask

  // Asserts reset, checks outputs respond asynchronously, releases at posedge+1.
  task automatic do_reset();
    rst = 1'b1;
    rsp_en = 1'b1; ready_en = 1'b1; dec_ready = 1'b1; redir = 1'b0; redir_pc = 32'h0;
    redirect = 1'b0; imem_rsp_valid = 1'b0;
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_fields", {op, func3, func7}, 0);
    q.delete();
    exp_pc = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        dr;
    logic        rv;
    logic [31:0] ra;
    logic        iv;
    logic [31:0] ipc;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // Streaming at latency 1, then decode stall (cycles 6-9) and release.
    tbl[0]  = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[2]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[3]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[4]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    tbl[5]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    tbl[6]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h0C};
    tbl[7]  = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h0C};
    tbl[8]  = '{1'b0, 1'b0, 32'h1C, 1'b1, 32'h0C};
    tbl[9]  = '{1'b0, 1'b0, 32'h1C, 1'b1, 32'h0C};
    tbl[10] = '{1'b1, 1'b0, 32'h1C, 1'b1, 32'h0C};
    tbl[11] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
    tbl[12] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
    tbl[13] = '{1'b1, 1'b1, 32'h24, 1'b1, 32'h18};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      dec_ready = tbl[i].dr;
      tick();
      chk($sformatf("tbl%0d_req_valid", i), s_rv, tbl[i].rv);
      chk($sformatf("tbl%0d_req_addr", i), s_ra, tbl[i].ra);
      chk($sformatf("tbl%0d_instr_valid", i), s_iv, tbl[i].iv);
      if (tbl[i].iv) chk($sformatf("tbl%0d_instr_pc", i), s_ipc, tbl[i].ipc);
    end

    // Redirect with two fetches in flight.
    do_reset();
    rsp_en = 1'b0;
    tick(); tick(); tick();
    redir = 1'b1; redir_pc = 32'h100;
    tick();
    chk("a_redirect_no_req", s_rv, 0);
    redir = 1'b0; rsp_en = 1'b1;
    tick();
    chk("a_req_valid", s_rv, 1);
    chk("a_req_addr", s_ra, 32'h100);
    chk("a_instr_valid_r1", s_iv, 0);
    tick();
    tick();
    chk("a_stale_dropped", s_iv, 0);
    tick();
    chk("a_first_valid", s_iv, 1);
    chk("a_first_pc", s_ipc, 32'h100);
    tick();
    chk("a_second_pc", s_ipc, 32'h104);

    // Redirect again while one stale response is still to be dropped.
    do_reset();
    rsp_en = 1'b0;
    tick(); tick(); tick(); tick();
    ready_en = 1'b0;
    redir = 1'b1; redir_pc = 32'h80;
    tick();
    redir = 1'b0; rsp_en = 1'b1;
    tick(); tick();
    rsp_en = 1'b0; redir = 1'b1; redir_pc = 32'h200;
    tick();
    redir = 1'b0; rsp_en = 1'b1; ready_en = 1'b1;
    tick();
    chk("b_req_addr", s_ra, 32'h200);
    chk("b_req_valid", s_rv, 1);
    chk("b_instr_valid", s_iv, 0);
    tick();
    chk("b_old_dropped", s_iv, 0);
    tick();
    chk("b_first_valid", s_iv, 1);
    chk("b_first_pc", s_ipc, 32'h200);

    // Redirect coinciding with a response, misaligned target.
    do_reset();
    tick(); tick();
    ready_en = 1'b0; redir = 1'b1; redir_pc = 32'h303;
    tick();
    chk("c_redirect_no_req", s_rv, 0);
    redir = 1'b0; ready_en = 1'b1;
    tick();
    chk("c_req_valid", s_rv, 1);
    chk("c_req_addr_aligned", s_ra, 32'h300);
    chk("c_rsp_dropped", s_iv, 0);
    tick();
    tick();
    chk("c_first_valid", s_iv, 1);
    chk("c_first_pc", s_ipc, 32'h300);

    // Reset with three instructions buffered under a decode stall.
    do_reset();
    dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("d_buffered_valid", s_iv, 1);
    chk("d_stalled_pc", s_ipc, 32'h0);
    do_reset();
    tick();
    chk("d_idle_no_req", s_rv, 0);
    tick();
    chk("d_first_req_valid", s_rv, 1);
    chk("d_first_req_addr", s_ra, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_chk);
    $fatal(1, "timeout");
  end

endmodule
